// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : EX-stage ALU issue/capture controller (valid/ready both sides)
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_aluop,
  input  logic [3:0]  in_funct,
  input  logic        in_alusrc,
  input  logic        in_branch,
  input  logic [15:0] in_rs_data,
  input  logic [15:0] in_rt_data,
  input  logic [5:0]  in_imm,
  input  logic [2:0]  in_rd,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_input2,
  output logic [2:0]  alu_control,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_zero,
  output logic        out_taken,
  output logic [2:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [2:0]  dec_control;
  logic        dec_err;
  logic [15:0] dec_op2;
  logic [2:0]  rd_q;
  logic        branch_q;
  logic        err_q;

  always_comb begin
    dec_control = 3'b010;
    dec_err     = 1'b0;
    case (in_aluop)
      2'b01: dec_control = 3'b110;
      2'b10: begin
        case (in_funct)
          4'b0000: dec_control = 3'b010;
          4'b0010: dec_control = 3'b110;
          4'b0100: dec_control = 3'b000;
          4'b0101: dec_control = 3'b001;
          4'b1010: dec_control = 3'b111;
          default: dec_err     = 1'b1;
        endcase
      end
      default: dec_control = 3'b010;
    endcase
  end

  assign dec_op2 = in_alusrc ? {{10{in_imm[5]}}, in_imm} : in_rt_data;
  assign accept  = in_valid & in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: state_next = CAPT;
      CAPT: state_next = RESP;
      RESP: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      alu_input1  <= 16'h0000;
      alu_input2  <= 16'h0000;
      alu_control <= 3'b010;
      rd_q        <= 3'd0;
      branch_q    <= 1'b0;
      err_q       <= 1'b0;
      out_result  <= 16'h0000;
      out_zero    <= 1'b0;
      out_taken   <= 1'b0;
      out_rd      <= 3'd0;
      out_err     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        alu_input1  <= in_rs_data;
        alu_input2  <= dec_op2;
        alu_control <= dec_control;
        rd_q        <= in_rd;
        branch_q    <= in_branch;
        err_q       <= dec_err;
        out_err     <= 1'b0;
      end
      // ALU output is only trustworthy one cycle after it sampled the operands
      if (state == CAPT) begin
        out_result <= alu_result;
        out_zero   <= alu_zero;
        out_taken  <= branch_q & alu_zero;
        out_rd     <= rd_q;
        out_err    <= err_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl : directed + randomized bench with registered ALU model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_aluop = 2'b00;
  logic [3:0]  in_funct = 4'b0000;
  logic        in_alusrc = 1'b0;
  logic        in_branch = 1'b0;
  logic [15:0] in_rs_data = 16'h0000;
  logic [15:0] in_rt_data = 16'h0000;
  logic [5:0]  in_imm = 6'd0;
  logic [2:0]  in_rd = 3'd0;
  logic [15:0] alu_input1;
  logic [15:0] alu_input2;
  logic [2:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_taken;
  logic [2:0]  out_rd;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic        alusrc;
    logic        branch;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [5:0]  imm;
    logic [2:0]  rd;
  } req_t;

  alu_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_alusrc(in_alusrc),
    .in_branch(in_branch), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_rd(in_rd),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken),
    .out_rd(out_rd), .out_err(out_err)
  );

  always #5 clock = ~clock;

  // Registered ALU sitting next to the controller; it has no reset
  always @(posedge clock) begin
    logic [15:0] r;
    case (alu_control)
      3'b010:  r = alu_input1 + alu_input2;
      3'b110:  r = alu_input1 - alu_input2;
      3'b000:  r = alu_input1 & alu_input2;
      3'b001:  r = alu_input1 | alu_input2;
      3'b111:  r = (alu_input1 < alu_input2) ? 16'd1 : 16'd0;
      default: r = 16'hDEAD;
    endcase
    alu_result <= r;
    alu_zero   <= (r == 16'h0000);
  end

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: operation chosen by name, then evaluated arithmetically
  task automatic model(input req_t r, output logic [2:0] ctrl, output logic [15:0] op2,
                       output logic [15:0] res, output logic zero, output logic taken,
                       output logic err);
    int op;  // 0 add, 1 sub, 2 and, 3 or, 4 slt
    int sx;
    op  = 0;
    err = 1'b0;
    if (r.aluop == 2'b01) op = 1;
    else if (r.aluop == 2'b10) begin
      if      (r.funct == 4'd0)  op = 0;
      else if (r.funct == 4'd2)  op = 1;
      else if (r.funct == 4'd4)  op = 2;
      else if (r.funct == 4'd5)  op = 3;
      else if (r.funct == 4'd10) op = 4;
      else err = 1'b1;
    end
    sx  = $signed(r.imm);
    op2 = r.alusrc ? sx[15:0] : r.rt;
    case (op)
      1:       begin ctrl = 3'b110; res = r.rs - op2; end
      2:       begin ctrl = 3'b000; res = r.rs & op2; end
      3:       begin ctrl = 3'b001; res = r.rs | op2; end
      4:       begin ctrl = 3'b111; res = (r.rs < op2) ? 16'd1 : 16'd0; end
      default: begin ctrl = 3'b010; res = r.rs + op2; end
    endcase
    zero  = (res == 16'h0000);
    taken = r.branch & zero;
  endtask

  task automatic send(input req_t r, input int hold);
    logic [2:0]  ec;
    logic [15:0] eop2, er;
    logic        ez, et, ee;
    int          n;
    model(r, ec, eop2, er, ez, et, ee);
    in_aluop = r.aluop; in_funct = r.funct; in_alusrc = r.alusrc; in_branch = r.branch;
    in_rs_data = r.rs; in_rt_data = r.rt; in_imm = r.imm; in_rd = r.rd;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check("in_ready_at_accept", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("exec_ctrl", alu_control, ec);
    check("exec_in1", alu_input1, r.rs);
    check("exec_in2", alu_input2, eop2);
    check("exec_valid", out_valid, 1'b0);
    @(posedge clock); #1;
    check("capt_valid", out_valid, 1'b0);
    @(posedge clock); #1;
    check("resp_valid", out_valid, 1'b1);
    check("resp_result", out_result, er);
    check("resp_zero", out_zero, ez);
    check("resp_taken", out_taken, et);
    check("resp_rd", out_rd, r.rd);
    check("resp_err", out_err, ee);
    check("resp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", out_result, er);
      check("hold_taken", out_taken, et);
      check("hold_err", out_err, ee);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_in2", alu_input2, eop2);
    end
  endtask

  task automatic done();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("done_valid", out_valid, 1'b0);
    check("done_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    req_t r;
    logic pend;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_result", out_result, 16'h0000);
    check("rst_zero", out_zero, 1'b0);
    check("rst_taken", out_taken, 1'b0);
    check("rst_rd", out_rd, 3'd0);
    check("rst_err", out_err, 1'b0);
    check("rst_in1", alu_input1, 16'h0000);
    check("rst_in2", alu_input2, 16'h0000);
    check("rst_ctrl", alu_control, 3'b010);
    reset = 1'b1;
    @(posedge clock); #1;
    check("idle_in_ready", in_ready, 1'b1);

    // R-type ADD overflow into bit 15
    r = '{aluop:2'b10, funct:4'b0000, alusrc:1'b0, branch:1'b0, rs:16'h7FFF, rt:16'h0001, imm:6'd0, rd:3'd1};
    send(r, 0); done();
    // Branch equal, then not equal
    r = '{aluop:2'b01, funct:4'b0000, alusrc:1'b0, branch:1'b1, rs:16'h1234, rt:16'h1234, imm:6'd0, rd:3'd2};
    send(r, 0); done();
    r.rt = 16'h1235;
    send(r, 0); done();
    // SLT with sign-extended immediate -1
    r = '{aluop:2'b10, funct:4'b1010, alusrc:1'b1, branch:1'b0, rs:16'h0003, rt:16'h0000, imm:6'b111111, rd:3'd3};
    send(r, 0); done();
    // Add-immediate with negative immediate
    r = '{aluop:2'b11, funct:4'b0000, alusrc:1'b1, branch:1'b0, rs:16'h0005, rt:16'h0000, imm:6'b111110, rd:3'd4};
    send(r, 4);
    // Back-to-back accept in the release edge; illegal funct then legal
    out_ready = 1'b1;
    r = '{aluop:2'b10, funct:4'b1111, alusrc:1'b0, branch:1'b0, rs:16'h0010, rt:16'h0020, imm:6'd0, rd:3'd5};
    send(r, 1);
    out_ready = 1'b1;
    r = '{aluop:2'b10, funct:4'b0101, alusrc:1'b0, branch:1'b0, rs:16'h00F0, rt:16'h0F00, imm:6'd0, rd:3'd6};
    send(r, 0); done();

    // Reset asserted during CAPT abandons the operation
    in_aluop = 2'b00; in_alusrc = 1'b0; in_rs_data = 16'h1111; in_rt_data = 16'h2222; in_rd = 3'd7;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", out_result, 16'h0000);
    check("mid_rst_rd", out_rd, 3'd0);
    check("mid_rst_ctrl", alu_control, 3'b010);
    check("mid_rst_in1", alu_input1, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end

    // Randomized requests with random backpressure and back-to-back issue
    pend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r.aluop  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: r.funct = 4'b0000;
        1: r.funct = 4'b0010;
        2: r.funct = 4'b0100;
        3: r.funct = 4'b0101;
        4: r.funct = 4'b1010;
        default: r.funct = 4'($urandom);
      endcase
      r.alusrc = 1'($urandom);
      r.branch = 1'($urandom);
      r.rs     = 16'($urandom);
      r.rt     = ($urandom_range(0, 3) == 0) ? r.rs : 16'($urandom);
      r.imm    = 6'($urandom);
      r.rd     = 3'($urandom);
      if (pend) begin
        if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
        else done();
      end
      send(r, $urandom_range(0, 3));
      pend = 1'b1;
    end
    done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue-side controller for the EX-stage ALU of the 16-bit processor. It accepts decoded instructions from ID/EX over a valid/ready handshake, translates ALUOp/funct into the 3-bit ALU control code, and drives the ALU operand inputs. Because the ALU registers its result on the clock edge, this block tracks that one-cycle latency, captures result and zero, and presents them to EX/MEM with a valid/ready handshake and branch resolution.

## Interface
- No parameters. Data width is fixed at 16 bits.
- `clock`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `in_aluop`  in  2  00 load/store add, 01 branch sub, 10 R-type (use funct), 11 add-immediate.
- `in_funct`  in  4  R-type function field.
- `in_alusrc`  in  1  1 selects sign-extended immediate as operand 2.
- `in_branch`  in  1  instruction is a beq.
- `in_rs_data`  in  16  operand 1.
- `in_rt_data`  in  16  register operand 2.
- `in_imm`  in  6  immediate, two's complement.
- `in_rd`  in  3  destination tag, passed through unchanged.
- `alu_input1`  out  16  to ALU `input1`.
- `alu_input2`  out  16  to ALU `input2`.
- `alu_control`  out  3  to ALU `ALUControl`.
- `alu_result`  in  16  from ALU `result`.
- `alu_zero`  in  1  from ALU `zero`.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  EX/MEM can accept the response.
- `out_result`  out  16  captured ALU result.
- `out_zero`  out  1  captured zero flag.
- `out_taken`  out  1  branch taken: registered `in_branch` AND captured zero.
- `out_rd`  out  3  tag of the response.
- `out_err`  out  1  illegal R-type funct.

## Operation
- **Decode**
  - aluop 00 or 11 → 010 (ADD). aluop 01 → 110 (SUB).
  - aluop 10 with funct 0000 → 010 (ADD), 0010 → 110 (SUB), 0100 → 000 (AND), 0101 → 001 (OR), 1010 → 111 (SLT).
  - Any other funct → 010, and err is latched to 1.
  - The block never drives codes 011, 100 or 101 to the ALU.
- **Operands**
  - input1 = rs_data.
  - input2 = alusrc ? {{10{imm[5]}}, imm} : rt_data.
  - Both are registered at accept and held stable until the next accept.
- **Arithmetic**
  - All operations are modulo 2^16.
  - SLT is an unsigned compare done in the ALU. This block only forwards the result.
- **FSM states:** IDLE, EXEC, CAPT, RESP.
  - IDLE: in_ready=1. On in_valid, go to EXEC and latch operands, control, rd, branch and err.
  - EXEC: the ALU samples the operands at the end of this cycle. Go to CAPT unconditionally.
  - CAPT: the ALU output is now valid. Latch alu_result and alu_zero into the out registers and compute taken. Go to RESP.
  - RESP: out_valid=1; out regs hold.
    - out_ready=0: stay in RESP.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: go to EXEC and latch the new request in the same edge.
- **in_ready** = (state==IDLE) | (state==RESP & out_ready).
- The ALU has no reset. Its outputs are ignored in every state except CAPT.

## Timing
- Request accepted at edge k:
  - operands and control are on the ALU pins during cycle k→k+1;
  - ALU result updates at edge k+1;
  - result is captured at edge k+2;
  - out_valid=1 from edge k+2 until the handshake completes.
- Minimum accept-to-accept interval is 3 cycles (back-to-back via RESP&out_ready).
- Outputs are stable while out_valid=1 and out_ready=0.
- **Reset (reset=0 at an edge):**
  - state→IDLE;
  - out_valid=0, out_result=0, out_zero=0, out_taken=0, out_rd=0, out_err=0;
  - alu_input1=0, alu_input2=0, alu_control=010.
- Reset asserted in EXEC, CAPT or RESP abandons the operation. No response is issued for it.
- in_valid is ignored when in_ready=0. The producer holds the request until in_ready.
- out_err applies only to its own response and is cleared on the next accept.

## Test plan
- **R-type ADD:** rs=0x7FFF, rt=0x0001, aluop=10, funct=0000 → alu_control=010, out_result=0x8000, out_zero=0, out_valid 2 edges after accept.
- **Branch equal:** rs=rt=0x1234, aluop=01, branch=1 → control 110, out_result=0, out_zero=1, out_taken=1. Repeat with rt=0x1235 → out_taken=0.
- **Immediate SLT and sign extension:**
  - rs=0x0003, imm=6'b111111, alusrc=1, aluop=10, funct=1010 → alu_input2=0xFFFF, out_result=1.
  - aluop=11, rs=5, imm=6'b111110 → out_result=0x0003.
- **Backpressure and back-to-back:**
  - Hold out_ready=0 for 4 cycles → out_* stable, in_ready=0.
  - Then raise out_ready with a new in_valid → new request accepted in the same edge; second out_valid 3 cycles later.
- **Illegal funct:** funct=1111 → alu_control=010, out_err=1. The next legal request gives out_err=0.
- **Reset mid-operation:** reset=0 during CAPT → all out_* zero, state IDLE, in_ready=1 after release; no spurious out_valid.
